// File: rtl/painterengine_gpu_blend_pipe_pkg.sv
// Shared definitions for the PainterEngine GPU blend pipeline.
// PAINTERENGINE_GPU_BLEND_ROUND_EN turns the >>CW shifts into round-half-up.
package painterengine_gpu_blend_pipe_pkg;

  typedef enum logic [1:0] {
    BlendAlphaOver = 2'd0,
    BlendAdd       = 2'd1,
    BlendMultiply  = 2'd2,
    BlendCopy      = 2'd3
  } blend_mode_e;

  // Pixel layouts for src/dst/out; the blend word is always A,R,G,B MSB-first.
  localparam int unsigned AlphaPosArgb = 0;
  localparam int unsigned AlphaPosBgra = 1;

`ifdef PAINTERENGINE_GPU_BLEND_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

endpackage

// File: rtl/painterengine_gpu_blend_channel.sv
// One colour channel of the blend pipe: stage-2 products, stage-3 sum/shift/saturate.
// Rounding follows PAINTERENGINE_GPU_BLEND_ROUND_EN through the package.
module painterengine_gpu_blend_channel
  import painterengine_gpu_blend_pipe_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  blend_mode_e   mode,
  input  logic [CW-1:0] wa,
  input  logic [CW-1:0] ws,
  input  logic [CW-1:0] dst,
  output logic [CW-1:0] result
);

  localparam int unsigned PW = 2 * CW + 1;
  localparam int unsigned SW = 2 * CW + 2;
  localparam logic [CW-1:0] Max = '1;
  localparam logic [PW-1:0] Full = PW'(1) << CW;
  localparam logic [SW-1:0] Rnd = RoundEn ? (SW'(1) << (CW - 1)) : '0;

  function automatic logic [CW-1:0] sat(input logic [SW-1:0] x);
    return (x > SW'(Max)) ? Max : x[CW-1:0];
  endfunction

  logic [PW-1:0] p0_d, p0_q, p1_d, p1_q;
  blend_mode_e   mode_q;
  logic [SW-1:0] sum, shifted;
  logic [CW-1:0] result_d, result_q;

  always_comb begin
    p0_d = '0;
    p1_d = '0;
    unique case (mode)
      BlendAlphaOver: begin
        p0_d = PW'(dst) * (Full - PW'(wa));
        p1_d = PW'(ws) * (PW'(wa) + PW'(1));
      end
      BlendAdd: begin
        p0_d = PW'(dst);
        p1_d = PW'(ws);
      end
      BlendMultiply: p0_d = PW'(dst) * (PW'(ws) + PW'(1));
      BlendCopy:     p1_d = PW'(ws);
    endcase
  end

  always_comb begin
    sum     = SW'(p0_q) + SW'(p1_q);
    shifted = sum;
    if (mode_q == BlendAlphaOver || mode_q == BlendMultiply) begin
      shifted = (sum + Rnd) >> CW;
    end
    result_d = sat(shifted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q     <= '0;
      p1_q     <= '0;
      mode_q   <= BlendAlphaOver;
      result_q <= '0;
    end else if (en) begin
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      mode_q   <= mode;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/painterengine_gpu_blend_pipe.sv
// 3-stage pixel blend pipe: stage-1 weighting, stage-2 products, stage-3 sum/shift/saturate.
// Build option PAINTERENGINE_GPU_BLEND_ROUND_EN rounds the ALPHA_OVER and MULTIPLY shifts.
module painterengine_gpu_blend_pipe
  import painterengine_gpu_blend_pipe_pkg::*;
#(
  parameter int unsigned CW        = 8,
  parameter int unsigned ALPHA_POS = AlphaPosArgb
) (
  input  logic            i_wire_clock,
  input  logic            i_wire_resetn,
  input  logic            i_wire_valid,
  output logic            o_wire_ready,
  input  logic [1:0]      i_wire_mode,
  input  logic [4*CW-1:0] i_wire_src,
  input  logic [4*CW-1:0] i_wire_dst,
  input  logic [4*CW-1:0] i_wire_blend,
  output logic            o_wire_valid,
  input  logic            i_wire_ready,
  output logic [4*CW-1:0] o_wire_data
);

  localparam int unsigned PW = 2 * CW + 1;
  localparam int unsigned SW = 2 * CW + 2;
  localparam logic [CW-1:0] Max = '1;
  localparam logic [PW-1:0] Full = PW'(1) << CW;
  localparam logic [SW-1:0] Rnd = RoundEn ? (SW'(1) << (CW - 1)) : '0;

  // Lanes are held internally in ARGB order: [3]=A, [2]=R, [1]=G, [0]=B.
  // The layout mapping is a self-inverse permutation, so it packs and unpacks.
  function automatic logic [3:0][CW-1:0] swizzle(input logic [4*CW-1:0] pix);
    logic [3:0][CW-1:0] res;
    for (int k = 0; k < 4; k++) begin
      res[k] = (ALPHA_POS == AlphaPosBgra) ? pix[(3-k)*CW +: CW] : pix[k*CW +: CW];
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [SW-1:0] x);
    return (x > SW'(Max)) ? Max : x[CW-1:0];
  endfunction

  logic               en;
  logic               v1_q, v2_q, v3_q;
  blend_mode_e        mode1_q, mode2_q;
  logic [3:0][CW-1:0] src_ch, dst_ch, bl_ch, ws_d, ws1_q, dst1_q, out_ch;
  logic [PW-1:0]      pa0_d, pa0_q, pa1_d, pa1_q;
  logic [SW-1:0]      asum, ashr;
  logic [CW-1:0]      a_d, a3_q;
  logic [2:0][CW-1:0] col;

  assign en           = !v3_q || i_wire_ready;
  assign o_wire_ready = en;
  assign o_wire_valid = v3_q;

  assign src_ch = swizzle(i_wire_src);
  assign dst_ch = swizzle(i_wire_dst);
  assign bl_ch  = i_wire_blend;

  always_comb begin
    ws_d = '0;
    for (int k = 0; k < 4; k++) begin
      ws_d[k] = sat(SW'(((2 * CW)'(src_ch[k]) * (2 * CW)'(bl_ch[k])) >> (CW - 1)));
    end
  end

  always_comb begin
    pa0_d = '0;
    pa1_d = '0;
    unique case (mode1_q)
      BlendAlphaOver: pa0_d = (Full - PW'(dst1_q[3])) * PW'(Max - ws1_q[3]);
      BlendAdd: begin
        pa0_d = PW'(dst1_q[3]);
        pa1_d = PW'(ws1_q[3]);
      end
      BlendMultiply:  pa0_d = PW'(dst1_q[3]);
      BlendCopy:      pa1_d = PW'(ws1_q[3]);
    endcase
  end

  always_comb begin
    asum = SW'(pa0_q) + SW'(pa1_q);
    ashr = (asum + Rnd) >> CW;
    if (mode2_q == BlendAlphaOver) begin
      a_d = Max - sat(ashr);
    end else begin
      a_d = sat(asum);
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      mode1_q <= BlendAlphaOver;
      mode2_q <= BlendAlphaOver;
      ws1_q   <= '0;
      dst1_q  <= '0;
      pa0_q   <= '0;
      pa1_q   <= '0;
      a3_q    <= '0;
    end else if (en) begin
      v1_q    <= i_wire_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      mode1_q <= blend_mode_e'(i_wire_mode);
      mode2_q <= mode1_q;
      ws1_q   <= ws_d;
      dst1_q  <= dst_ch;
      pa0_q   <= pa0_d;
      pa1_q   <= pa1_d;
      a3_q    <= a_d;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_chan
    painterengine_gpu_blend_channel #(
      .CW(CW)
    ) u_chan (
      .clk   (i_wire_clock),
      .rst_n (i_wire_resetn),
      .en    (en),
      .mode  (mode1_q),
      .wa    (ws1_q[3]),
      .ws    (ws1_q[k]),
      .dst   (dst1_q[k]),
      .result(col[k])
    );
  end

  assign out_ch      = {a3_q, col};
  assign o_wire_data = swizzle(out_ch);

endmodule

// File: tb/tb_painterengine_gpu_blend_pipe.sv
// Self-checking bench for painterengine_gpu_blend_pipe (both channel layouts, CW=8).
module tb_painterengine_gpu_blend_pipe;

`ifdef PAINTERENGINE_GPU_BLEND_ROUND_EN
  localparam int Rnd = 128;
  localparam logic [31:0] ExpV0 = 32'hFFFF0001;
  localparam logic [31:0] ExpV1 = 32'hFF800080;
`else
  localparam int Rnd = 0;
  localparam logic [31:0] ExpV0 = 32'hFFFF0000;
  localparam logic [31:0] ExpV1 = 32'hFF80007F;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] src = '0, dst = '0, blend = '0;
  logic        ready0, ready1, ov0, ov1;
  logic [31:0] od0, od1;

  always #5 clk = ~clk;

  painterengine_gpu_blend_pipe #(.CW(8), .ALPHA_POS(0)) dut0 (
    .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_valid(in_valid), .o_wire_ready(ready0),
    .i_wire_mode(mode), .i_wire_src(src), .i_wire_dst(dst), .i_wire_blend(blend),
    .o_wire_valid(ov0), .i_wire_ready(out_ready), .o_wire_data(od0)
  );

  painterengine_gpu_blend_pipe #(.CW(8), .ALPHA_POS(1)) dut1 (
    .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_valid(in_valid), .o_wire_ready(ready1),
    .i_wire_mode(mode), .i_wire_src(src), .i_wire_dst(dst), .i_wire_blend(blend),
    .o_wire_valid(ov1), .i_wire_ready(out_ready), .o_wire_data(od1)
  );

  int total = 0, bad = 0, cyc = 0, nout = 0;
  logic [31:0] q0[$], q1[$];
  int qc[$];
  bit lat_chk = 0, chk_stall = 0, acc = 0, fired = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] src, dst, blend, exp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h, want nothing pending", name, act);
  endtask

  // Channel k in A,R,G,B order (k=0 is A) for the given layout.
  function automatic int chan(input logic [31:0] pix, input int k, input int apos);
    int sh;
    sh = (apos != 0) ? 8 * k : 24 - 8 * k;
    return int'((pix >> sh) & 32'hFF);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] s,
                                        input logic [31:0] d, input logic [31:0] b,
                                        input int apos);
    int ws[4], dc[4], oc[4], sh;
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ws[k] = (chan(s, k, apos) * chan(b, k, 0)) / 128;
      if (ws[k] > 255) ws[k] = 255;
      dc[k] = chan(d, k, apos);
    end
    case (m)
      2'd0: begin
        oc[0] = 255 - ((256 - dc[0]) * (255 - ws[0]) + Rnd) / 256;
        for (int k = 1; k < 4; k++) oc[k] = (dc[k] * (256 - ws[0]) + ws[k] * (ws[0] + 1) + Rnd) / 256;
      end
      2'd1: for (int k = 0; k < 4; k++) oc[k] = dc[k] + ws[k];
      2'd2: begin
        oc[0] = dc[0];
        for (int k = 1; k < 4; k++) oc[k] = (dc[k] * (ws[k] + 1) + Rnd) / 256;
      end
      default: for (int k = 0; k < 4; k++) oc[k] = ws[k];
    endcase
    for (int k = 0; k < 4; k++) begin
      if (oc[k] > 255) oc[k] = 255;
      sh = (apos != 0) ? 8 * k : 24 - 8 * k;
      r = r | (32'(oc[k]) << sh);
    end
    return r;
  endfunction

  // One clock: drive at negedge, sample 2 units later (well before posedge).
  task automatic cycle(input logic v, input logic [1:0] m, input logic [31:0] s,
                       input logic [31:0] d, input logic [31:0] b, input logic rdy,
                       input bit use_exp, input logic [31:0] e0, input logic [31:0] e1);
    logic [31:0] x0, x1;
    int c;
    in_valid = v; mode = m; src = s; dst = d; blend = b; out_ready = rdy;
    #2;
    acc = v && ready0;
    fired = 0;
    if (chk_stall && !rdy && ov0) check("stall_ready", 32'(ready0), 32'h0);
    if (ov0 && rdy) begin
      fired = 1;
      nout++;
      check("valid_apos1", 32'(ov1), 32'h1);
      if (q0.size() == 0) begin
        fail_now("unexpected_output", od0);
      end else begin
        x0 = q0.pop_front();
        x1 = q1.pop_front();
        c = qc.pop_front();
        check("data_apos0", od0, x0);
        check("data_apos1", od1, x1);
        if (lat_chk) check("latency", 32'(cyc - c), 32'd3);
      end
    end
    if (acc) begin
      q0.push_back(use_exp ? e0 : model(m, s, d, b, 0));
      q1.push_back(use_exp ? e1 : model(m, s, d, b, 1));
      qc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, '0, '0, rdy, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, sent, stall, nacc;
    bit seen;
    logic [1:0] pm;
    logic [31:0] ps, pd, pb;

    vecs[0] = '{2'd0, 32'hFFFF0000, 32'hFF0000FF, 32'hFFFFFFFF, ExpV0};
    vecs[1] = '{2'd0, 32'h80FF0000, 32'hFF0000FF, 32'h80808080, ExpV1};
    vecs[2] = '{2'd1, 32'h40C01020, 32'h40808080, 32'h80808080, 32'h80FF90A0};
    vecs[3] = '{2'd2, 32'h00FF8000, 32'h7F404040, 32'hFFFFFFFF, 32'h7F404000};
    vecs[4] = '{2'd3, 32'h12345678, 32'hDEADBEEF, 32'h80808080, 32'h12345678};

    #1;
    check("reset_valid", 32'(ov0), 32'h0);
    check("reset_data", od0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(ready0), 32'h1);
    @(negedge clk);

    // Directed vectors, one at a time, latency checked.
    lat_chk = 1;
    n0 = nout;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].blend, 1'b1, 1'b1,
            vecs[i].exp, model(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].blend, 1));
      idle(3, 1'b1);
    end
    check("table_outputs", 32'(nout - n0), 32'd5);

    // Alpha-in-low-lane layout: copy keeps A where it was.
    cycle(1'b1, 2'd3, 32'h000000FF, 32'h11223344, 32'h80808080, 1'b1, 1'b1,
          model(2'd3, 32'h000000FF, 32'h11223344, 32'h80808080, 0), 32'h000000FF);
    idle(3, 1'b1);

    // Back-to-back pixels with per-pixel mode changes: full rate, no bubble.
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 2'(i % 4), $urandom, $urandom, $urandom, 1'b1, 1'b0, '0, '0);
      if (acc) nacc++;
    end
    idle(3, 1'b1);
    check("stream_accepts", 32'(nacc), 32'd8);
    lat_chk = 0;

    // Backpressure: 6 pixels, ready low for 5 cycles after the first output.
    chk_stall = 1;
    n0 = nout; sent = 0; stall = 0; seen = 0;
    ps = $urandom; pd = $urandom; pb = $urandom;
    for (int t = 0; t < 60 && (sent < 6 || q0.size() != 0); t++) begin
      cycle(sent < 6, 2'(sent % 4), ps, pd, pb, stall == 0, 1'b0, '0, '0);
      if (acc) begin
        sent++;
        ps = $urandom; pd = $urandom; pb = $urandom;
      end
      if (stall > 0) stall--;
      else if (fired && !seen) begin
        seen = 1;
        stall = 5;
      end
    end
    check("bp_outputs", 32'(nout - n0), 32'd6);
    if (q0.size() != 0) fail_now("bp_drain", 32'(q0.size()));

    // Randomized traffic with random stalls, checked against the model.
    pm = 2'($urandom); ps = $urandom; pd = $urandom; pb = $urandom;
    for (int t = 0; t < 400; t++) begin
      cycle($urandom_range(0, 3) != 0, pm, ps, pd, pb, $urandom_range(0, 9) < 7, 1'b0, '0, '0);
      if (acc) begin
        pm = 2'($urandom); ps = $urandom; pd = $urandom; pb = $urandom;
      end
    end
    for (int t = 0; t < 20 && q0.size() != 0; t++) idle(1, 1'b1);
    if (q0.size() != 0) fail_now("random_drain", 32'(q0.size()));
    chk_stall = 0;

    // Reset with three pixels in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), $urandom, $urandom, $urandom, 1'b1, 1'b0, '0, '0);
    check("pre_reset_valid", 32'(ov0), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_valid0", 32'(ov0), 32'h0);
    check("rst_data0", od0, 32'h0);
    check("rst_valid1", 32'(ov1), 32'h0);
    check("rst_data1", od1, 32'h0);
    q0.delete(); q1.delete(); qc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n0 = nout;
    idle(6, 1'b1);
    check("post_reset_outputs", 32'(nout - n0), 32'd0);
    cycle(1'b1, 2'd1, 32'h40C01020, 32'h40808080, 32'h80808080, 1'b1, 1'b1, 32'h80FF90A0,
          model(2'd1, 32'h40C01020, 32'h40808080, 32'h80808080, 1));
    idle(3, 1'b1);
    check("post_reset_new", 32'(nout - n0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
